// File: rtl/jtag_host_pkg.sv
// Shared op codes, FSM states and TMS walk patterns for the JTAG host master.
package jtag_host_pkg;

  typedef enum logic [1:0] {
    OP_RESET    = 2'd0,
    OP_IDLE     = 2'd1,
    OP_SHIFT_IR = 2'd2,
    OP_SHIFT_DR = 2'd3
  } jtag_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_SHIFT,
    ST_POST,
    ST_DONE
  } jtag_state_e;

  // TMS patterns are applied LSB first, one bit per TCK
  localparam logic [7:0] RST_TMS    = 8'b0001_1111;
  localparam logic [2:0] RST_LEN    = 3'd6;
  localparam logic [7:0] PRE_IR_TMS = 8'b0000_0011;
  localparam logic [2:0] PRE_IR_LEN = 3'd4;
  localparam logic [7:0] PRE_DR_TMS = 8'b0000_0001;
  localparam logic [2:0] PRE_DR_LEN = 3'd3;
  localparam logic [7:0] POST_TMS   = 8'b0000_0001;
  localparam logic [2:0] POST_LEN   = 3'd2;

  function automatic logic pre_tms(input jtag_op_e op, input logic [2:0] step);
    case (op)
      OP_RESET:    return RST_TMS[step];
      OP_SHIFT_IR: return PRE_IR_TMS[step];
      OP_SHIFT_DR: return PRE_DR_TMS[step];
      default:     return 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] pre_len(input jtag_op_e op);
    case (op)
      OP_RESET:    return RST_LEN;
      OP_SHIFT_IR: return PRE_IR_LEN;
      OP_SHIFT_DR: return PRE_DR_LEN;
      default:     return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/jtag_host_master_tck_gen.sv
// TCK divider: one lead cycle after enable, then CLK_DIV low / CLK_DIV high.
module jtag_tck_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic en_i,
  output logic tck_o,
  output logic fall_stb_o,
  output logic rise_stb_o
);

  localparam int CW = $clog2(CLK_DIV + 1);

  logic [CW-1:0] cnt;
  logic          act;
  logic          last;

  assign last = (cnt == CW'(CLK_DIV - 1));
  // fall_stb marks the edge that starts a new low phase (first one is the lead cycle)
  assign fall_stb_o = en_i & (~act | (last & tck_o));
  assign rise_stb_o = en_i & act & last & ~tck_o;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      tck_o <= 1'b0;
      cnt   <= '0;
      act   <= 1'b0;
    end else if (!en_i) begin
      tck_o <= 1'b0;
      cnt   <= '0;
      act   <= 1'b0;
    end else if (!act) begin
      act   <= 1'b1;
      cnt   <= '0;
      tck_o <= 1'b0;
    end else if (last) begin
      cnt   <= '0;
      tck_o <= ~tck_o;
    end else begin
      cnt   <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/jtag_host_master.sv
// JTAG host: turns reset/idle/IR/DR commands into TCK/TMS/TDI sequences and captures TDO.
module jtag_host_master
  import jtag_host_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int DATA_W  = 32
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [1:0]        cmd_op_i,
  input  logic [5:0]        cmd_len_i,
  input  logic [DATA_W-1:0] cmd_wdata_i,
  output logic              rsp_valid_o,
  output logic [DATA_W-1:0] rsp_data_o,
  output logic              busy_o,
  output logic              tck_o,
  output logic              tms_o,
  output logic              tdi_o,
  input  logic              tdo_i
);

  jtag_state_e       state;
  jtag_op_e          op_q;
  logic [5:0]        len_q, bit_cnt, len_eff;
  logic [2:0]        step;
  logic [DATA_W-1:0] wdata_q, rdata_q;
  logic              tck_en, fall_stb, rise_stb;
  logic              pre_done, shift_last;

  assign cmd_ready_o = (state == ST_IDLE);
  assign busy_o      = ~cmd_ready_o;
  assign tck_en      = (state == ST_PRE) || (state == ST_SHIFT) || (state == ST_POST);

  always_comb begin
    len_eff = cmd_len_i;
    if (cmd_len_i == 6'd0)             len_eff = 6'd1;
    else if (32'(cmd_len_i) > DATA_W)  len_eff = 6'(DATA_W);
  end

  // OP_IDLE's preamble is N zeros, so it counts with the bit counter instead of step
  assign pre_done   = (op_q == OP_IDLE) ? (bit_cnt == len_q) : (step == pre_len(op_q));
  assign shift_last = (bit_cnt == len_q - 6'd1);

  jtag_tck_gen #(.CLK_DIV(CLK_DIV)) u_tck (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .en_i       (tck_en),
    .tck_o      (tck_o),
    .fall_stb_o (fall_stb),
    .rise_stb_o (rise_stb)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state       <= ST_IDLE;
      op_q        <= OP_RESET;
      len_q       <= '0;
      bit_cnt     <= '0;
      step        <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      tms_o       <= 1'b1;
      tdi_o       <= 1'b0;
      rsp_valid_o <= 1'b0;
      rsp_data_o  <= '0;
    end else begin
      rsp_valid_o <= 1'b0;
      unique case (state)
        ST_IDLE: if (cmd_valid_i) begin
          op_q    <= jtag_op_e'(cmd_op_i);
          len_q   <= len_eff;
          wdata_q <= cmd_wdata_i;
          rdata_q <= '0;
          bit_cnt <= '0;
          step    <= '0;
          state   <= ST_PRE;
        end
        ST_PRE: if (fall_stb) begin
          if (!pre_done) begin
            tms_o <= pre_tms(op_q, step);
            tdi_o <= 1'b0;
            if (op_q == OP_IDLE) bit_cnt <= bit_cnt + 6'd1;
            else                 step    <= step + 3'd1;
          end else if (op_q == OP_RESET || op_q == OP_IDLE) begin
            state       <= ST_DONE;
            rsp_valid_o <= 1'b1;
            rsp_data_o  <= rdata_q;
          end else begin
            state   <= ST_SHIFT;
            bit_cnt <= '0;
            tms_o   <= (len_q == 6'd1);
            tdi_o   <= wdata_q[0];
            wdata_q <= wdata_q >> 1;
          end
        end
        ST_SHIFT: begin
          if (rise_stb) rdata_q <= rdata_q | (DATA_W'(tdo_i) << bit_cnt);
          if (fall_stb) begin
            if (shift_last) begin
              state <= ST_POST;
              tms_o <= POST_TMS[0];
              tdi_o <= 1'b0;
              step  <= 3'd1;
            end else begin
              bit_cnt <= bit_cnt + 6'd1;
              tms_o   <= (bit_cnt + 6'd2 == len_q);
              tdi_o   <= wdata_q[0];
              wdata_q <= wdata_q >> 1;
            end
          end
        end
        ST_POST: if (fall_stb) begin
          if (step < POST_LEN) begin
            tms_o <= POST_TMS[step];
            step  <= step + 3'd1;
          end else begin
            state       <= ST_DONE;
            rsp_valid_o <= 1'b1;
            rsp_data_o  <= rdata_q;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jtag_host_master.sv
// Bench: IEEE 1149.1 TAP model with IDCODE behind the host; scoreboard on responses.
module tb_jtag_host_master;

  localparam logic [1:0] C_RST = 2'd0, C_IDLE = 2'd1, C_IR = 2'd2, C_DR = 2'd3;
  localparam logic [31:0] IDCODE = 32'h3002_AEFD;

  typedef enum logic [3:0] {TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PDR, EX2DR, UPDR,
                            SELIR, CAPIR, SHIR, EX1IR, PIR, EX2IR, UPIR} tap_e;

  logic        clk, rst;
  logic        cmd_valid, cmd_ready, rsp_valid, busy, tck, tms, tdi, tdo;
  logic [1:0]  cmd_op;
  logic [5:0]  cmd_len;
  logic [31:0] cmd_wdata, rsp_data;
  logic        valid2, ready2, rsp_valid2, busy2, tck2, tms2, tdi2;
  logic [1:0]  op2;
  logic [5:0]  len2;
  logic [31:0] rsp_data2;

  int n_tests = 0, n_fail = 0, cyc = 0;
  logic [31:0] exp_d_q[$];
  int          exp_l_q[$], acc_q[$], acc_hist[$], rsp_hist[$];
  string       tag_q[$];
  int          exp2_q[$], acc2_q[$], rise2_hist[$];
  logic        tms_hist[$], tms2_hist[$];
  logic        prev_tck2 = 1'b0;
  string       mt;
  int          ma;

  tap_e        tap_st = TLR;
  logic [3:0]  tap_ir = 4'h0, ir_sr = 4'h0;
  logic [31:0] dr_sr = 32'h0;
  logic        byp = 1'b0;

  jtag_host_master #(.CLK_DIV(2), .DATA_W(32)) dut (
    .clk_i(clk), .reset_i(rst), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_op_i(cmd_op), .cmd_len_i(cmd_len), .cmd_wdata_i(cmd_wdata),
    .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data), .busy_o(busy),
    .tck_o(tck), .tms_o(tms), .tdi_o(tdi), .tdo_i(tdo));

  jtag_host_master #(.CLK_DIV(1), .DATA_W(32)) dut2 (
    .clk_i(clk), .reset_i(rst), .cmd_valid_i(valid2), .cmd_ready_o(ready2),
    .cmd_op_i(op2), .cmd_len_i(len2), .cmd_wdata_i(32'h0),
    .rsp_valid_o(rsp_valid2), .rsp_data_o(rsp_data2), .busy_o(busy2),
    .tck_o(tck2), .tms_o(tms2), .tdi_o(tdi2), .tdo_i(1'b0));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int lat_of(input logic [1:0] op, input logic [5:0] len, input int div);
    int n, t;
    n = (len == 0) ? 1 : (len > 32) ? 32 : int'(len);
    case (op)
      C_RST:   t = 6;
      C_IDLE:  t = n;
      C_IR:    t = n + 6;
      default: t = n + 5;
    endcase
    return 2 * div * t + 1;
  endfunction

  function automatic tap_e tap_next(input tap_e s, input logic m);
    case (s)
      TLR:   return m ? TLR   : RTI;
      RTI:   return m ? SELDR : RTI;
      SELDR: return m ? SELIR : CAPDR;
      CAPDR: return m ? EX1DR : SHDR;
      SHDR:  return m ? EX1DR : SHDR;
      EX1DR: return m ? UPDR  : PDR;
      PDR:   return m ? EX2DR : PDR;
      EX2DR: return m ? UPDR  : SHDR;
      UPDR:  return m ? SELDR : RTI;
      SELIR: return m ? TLR   : CAPIR;
      CAPIR: return m ? EX1IR : SHIR;
      SHIR:  return m ? EX1IR : SHIR;
      EX1IR: return m ? UPIR  : PIR;
      PIR:   return m ? EX2IR : PIR;
      EX2IR: return m ? UPIR  : SHIR;
      default: return m ? SELDR : RTI;
    endcase
  endfunction

  // TAP: state and shifts on TCK rise, TDO on TCK fall
  always @(posedge tck) begin
    tms_hist.push_back(tms);
    case (tap_st)
      TLR:   tap_ir <= 4'h0;
      CAPDR: begin dr_sr <= IDCODE; byp <= 1'b0; end
      SHDR:  if (tap_ir == 4'h0) dr_sr <= {tdi, dr_sr[31:1]}; else byp <= tdi;
      CAPIR: ir_sr <= 4'b0001;
      SHIR:  ir_sr <= {tdi, ir_sr[3:1]};
      UPIR:  tap_ir <= ir_sr;
      default: ;
    endcase
    tap_st <= tap_next(tap_st, tms);
  end

  always @(negedge tck)
    tdo <= (tap_st == SHDR) ? ((tap_ir == 4'h0) ? dr_sr[0] : byp) :
           (tap_st == SHIR) ? ir_sr[0] : 1'b0;

  initial tdo = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      exp_d_q.delete(); exp_l_q.delete(); tag_q.delete(); acc_q.delete();
    end else begin
      if (cmd_valid && cmd_ready) begin acc_q.push_back(cyc + 1); acc_hist.push_back(cyc + 1); end
      if (rsp_valid) begin
        rsp_hist.push_back(cyc);
        if (exp_d_q.size() == 0 || acc_q.size() == 0) chk("spurious_rsp", 1, 0);
        else begin
          mt = tag_q.pop_front();
          ma = acc_q.pop_front();
          chk({mt, "_data"}, rsp_data, exp_d_q.pop_front());
          chk({mt, "_lat"}, cyc - ma, exp_l_q.pop_front());
        end
      end
    end
  end

  always @(negedge clk) begin
    prev_tck2 <= tck2;
    if (!rst) begin
      if (valid2 && ready2) acc2_q.push_back(cyc + 1);
      if (tck2 && !prev_tck2) begin rise2_hist.push_back(cyc); tms2_hist.push_back(tms2); end
      if (rsp_valid2) begin
        if (exp2_q.size() == 0 || acc2_q.size() == 0) chk("idle2_spurious", 1, 0);
        else begin
          chk("idle2_data", rsp_data2, 0);
          chk("idle2_lat", cyc - acc2_q.pop_front(), exp2_q.pop_front());
        end
      end
    end
  end

  task automatic wait_accept();
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (cmd_ready) break;
    end
    if (!cmd_ready) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic push_exp(input logic [1:0] op, input logic [5:0] len, input string tag,
                          input logic [31:0] d);
    exp_d_q.push_back(d);
    exp_l_q.push_back(lat_of(op, len, 2));
    tag_q.push_back(tag);
  endtask

  task automatic send(input logic [1:0] op, input logic [5:0] len, input logic [31:0] wd,
                      input string tag, input logic [31:0] d);
    push_exp(op, len, tag, d);
    cmd_op = op; cmd_len = len; cmd_wdata = wd; cmd_valid = 1'b1;
    wait_accept();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    for (int n = 0; n < 2000 && exp_d_q.size() != 0; n++) @(negedge clk);
    if (exp_d_q.size() != 0) chk("rsp_timeout", exp_d_q.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int t0, a0, r0, r2;
    logic [63:0] tv;
    logic tor;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_len = '0; cmd_wdata = '0;
    valid2 = 1'b0; op2 = '0; len2 = '0;
    repeat (3) @(posedge clk); #1;
    chk("rst_tck", tck, 0);       chk("rst_tms", tms, 1);   chk("rst_tdi", tdi, 0);
    chk("rst_rspv", rsp_valid, 0); chk("rst_rspd", rsp_data, 0);
    chk("rst_ready", cmd_ready, 1); chk("rst_busy", busy, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    t0 = tms_hist.size();
    send(C_RST, 6'd0, 32'hFFFF_FFFF, "reset", 32'h0);
    wait_rsp();
    chk("reset_ntck", tms_hist.size() - t0, 6);
    tv = '0;
    for (int i = 0; i < 6 && t0 + i < tms_hist.size(); i++) tv[i] = tms_hist[t0 + i];
    chk("reset_tms", tv, 64'h1F);
    chk("tap_rti", tap_st, RTI);
    chk("idle_tms_low", tms, 0);

    send(C_IR, 6'd4, 32'h0, "ir_idcode", 32'h1);
    wait_rsp();
    chk("ir_reg_idcode", tap_ir, 0);

    send(C_DR, 6'd32, 32'h0, "dr_idcode", IDCODE);
    wait_rsp();

    // back-to-back with valid held: len 40 clamps to 32, len 0 becomes 1
    push_exp(C_DR, 6'd40, "dr_len40", IDCODE);
    push_exp(C_DR, 6'd0, "dr_len0", 32'h1);
    t0 = tms_hist.size(); a0 = acc_hist.size(); r0 = rsp_hist.size();
    cmd_op = C_DR; cmd_len = 6'd40; cmd_wdata = 32'h1234_5678; cmd_valid = 1'b1;
    wait_accept();
    cmd_len = 6'd0;
    wait_accept();
    cmd_valid = 1'b0;
    wait_rsp();
    chk("b2b_ntck", tms_hist.size() - t0, 43);
    if (acc_hist.size() > a0 + 1 && rsp_hist.size() > r0)
      chk("b2b_gap", acc_hist[a0 + 1] - rsp_hist[r0], 2);
    else chk("b2b_missing", 0, 1);

    send(C_IR, 6'd4, 32'hF, "ir_bypass", 32'h1);
    wait_rsp();
    chk("ir_reg_bypass", tap_ir, 4'hF);
    send(C_DR, 6'd8, 32'hA5, "dr_bypass", 32'h4A);
    wait_rsp();

    // CLK_DIV=1 instance: idle clocks
    exp2_q.push_back(lat_of(C_IDLE, 6'd3, 1));
    r2 = rise2_hist.size();
    op2 = C_IDLE; len2 = 6'd3; valid2 = 1'b1;
    for (int n = 0; n < 50; n++) begin @(negedge clk); if (ready2) break; end
    @(posedge clk); #1;
    valid2 = 1'b0;
    for (int n = 0; n < 100 && exp2_q.size() != 0; n++) @(negedge clk);
    if (exp2_q.size() != 0) chk("idle2_timeout", exp2_q.size(), 0);
    chk("idle2_ntck", rise2_hist.size() - r2, 3);
    if (rise2_hist.size() >= r2 + 3)
      for (int i = 1; i < 3; i++) chk("idle2_period", rise2_hist[r2 + i] - rise2_hist[r2 + i - 1], 2);
    tor = 1'b0;
    for (int i = r2; i < tms2_hist.size(); i++) tor |= tms2_hist[i];
    chk("idle2_tms", tor, 0);
    @(posedge clk); #1;

    // abort a DR shift partway through bit 10
    t0 = tms_hist.size();
    send(C_DR, 6'd32, 32'h0, "dr_abort", IDCODE);
    for (int n = 0; n < 500 && tms_hist.size() < t0 + 14; n++) @(negedge clk);
    chk("abort_reached", tms_hist.size() >= t0 + 14, 1);
    #1 rst = 1'b1;
    #1;
    chk("abort_tck", tck, 0); chk("abort_tms", tms, 1);
    chk("abort_rspv", rsp_valid, 0); chk("abort_ready", cmd_ready, 1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    send(C_RST, 6'd0, 32'h0, "reset_after_abort", 32'h0);
    wait_rsp();
    send(C_DR, 6'd32, 32'hDEAD_BEEF, "dr_after_abort", IDCODE);
    wait_rsp();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
